fifo_lookahead_to_nl: RTL and testbench
=======================================

FIFO_LOOKAHEAD_TO_NL -- requirements
Module: fifo_lookahead_to_nl

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of every data word.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 _empty  input  1  upstream lookahead FIFO empty flag.
REQ-006 _dout  input  DATA_WIDTH  upstream head word, valid whenever _empty=0.
REQ-007 _rd  output  1  upstream pop strobe; _dout is consumed at the edge where _rd=1.
REQ-008 rd  input  1  downstream read request, non-lookahead semantics.
REQ-009 empty  output  1  downstream empty flag.
REQ-010 dout  output  DATA_WIDTH  downstream read data, registered.

Function
REQ-011 Block converts an upstream lookahead (first-word-fall-through) FIFO into a downstream non-lookahead FIFO read port.
REQ-012 Internal prefetch buffer: 2 entries of DATA_WIDTH; 1-bit write pointer, 1-bit read pointer, 2-bit occupancy count (0..2).
REQ-013 _rd = rst & !_empty & (count != 2); no combinational path from rd to _rd.
REQ-014 Push: at an edge with _rd=1, _dout is written to buf[wptr], and wptr toggles.
REQ-015 empty = (count == 0); depends on registered state only.
REQ-016 Pop: at an edge with rd=1 and empty=0, dout <= buf[rptr], and rptr toggles.
REQ-017 rd=1 while empty=1: ignored; dout, rptr and count hold; no underflow side effect.
REQ-018 dout holds its last value in every cycle without a pop.
REQ-019 Read latency: the word appears on dout exactly one cycle after the edge that sampled rd=1, empty=0.
REQ-020 Count update: push only +1; pop only -1; push and pop in the same edge leave it unchanged.
REQ-021 Full stall: count=2 forces _rd=0 regardless of _empty.
REQ-022 Pointers wrap 1->0 naturally (1-bit).
REQ-023 Sustained throughput: with _empty=0 and rd=1 continuously, one word per cycle after 2-cycle fill latency.
REQ-024 Ordering: words leave on dout in exactly the order they were popped from upstream; no loss, no duplication.
REQ-025 Upstream fall-through latency: word present at an edge with count<2 is buffered at that edge; empty deasserts after that edge.

Reset
REQ-026 rst=0 asynchronously forces count=0, wptr=0, rptr=0, dout=0, empty=1, _rd=0, independent of clk.
REQ-027 Buffer contents need not be reset; they are unobservable while count=0.
REQ-028 Reset asserted mid-transfer discards buffered words; after release the block resumes from the next upstream head word with no stale output.
REQ-029 First push may occur at the first rising edge after rst deasserts.

Verification
REQ-030 Reset: rst=0 with _empty=0 -> _rd=0, empty=1, dout=0 during reset, with no clock edge required.
REQ-031 Single word: upstream holds 0x5A, rd=0 -> after one edge empty=0, count=1; rd=1 at the next edge -> dout=0x5A one cycle later, then empty=1.
REQ-032 Streaming: upstream 0x5A,0xF6,0x09,0xC4,0x81,0xE2,0xA0,0x7A with rd=1 constant -> dout shows the same eight words in order on consecutive cycles after fill, then empty=1.
REQ-033 Backpressure: rd=0 with upstream non-empty -> exactly 2 pushes, then _rd=0 and count=2; rd=1 resumes in-order delivery with no loss.
REQ-034 Underflow: rd=1 with empty=1 for 5 cycles -> dout unchanged, count stays 0, and the first word after upstream fills is delivered correctly.
REQ-035 Random rd (50%) against random upstream availability over 1000 words -> scoreboard matches all words, and a mid-stream rst pulse yields no stale dout after release.

Source files
------------

// File: rtl/fifo_lookahead_to_nl.sv
// Adapts an upstream first-word-fall-through FIFO to a non-lookahead read port
// with registered dout, using a two-entry prefetch buffer.
module fifo_lookahead_to_nl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  _empty,
   input  logic [DATA_WIDTH-1:0] _dout,
   output logic                  _rd,
   input  logic                  rd,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] buffer [2];
   logic                  wptr;
   logic                  rptr;
   logic [1:0]            count;
   logic                  push;
   logic                  pop;

   // Prefetch depends only on registered occupancy, so rd never reaches _rd.
   assign _rd   = rst & ~_empty & (count != 2'd2);
   assign push  = _rd;
   assign empty = (count == 2'd0);
   assign pop   = rd & ~empty;

   // Storage is left unreset; entries are only read once count says they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         buffer[wptr] <= _dout;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= 2'd0;
         dout  <= '0;
      end else begin
         if (push) begin
            wptr <= ~wptr;
         end
         if (pop) begin
            rptr <= ~rptr;
            dout <= buffer[rptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_lookahead_to_nl.sv
// Directed and random checks of the lookahead-to-non-lookahead FIFO adapter,
// with a queue model of the upstream FIFO and of the prefetch buffer.
module tb_fifo_lookahead_to_nl;

   logic       clk;
   logic       rst;
   logic       up_empty;
   logic [7:0] up_dout;
   logic       up_rd;
   logic       rd;
   logic       empty;
   logic [7:0] dout;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] up_q[$];
   logic [7:0] m_q[$];
   logic [7:0] exp_dout;
   logic       up_avail;
   logic       obs_up_rd;
   logic       exp_up_rd;
   logic       last_pop;

   fifo_lookahead_to_nl #(.DATA_WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      ._empty (up_empty),
      ._dout  (up_dout),
      ._rd    (up_rd),
      .rd     (rd),
      .empty  (empty),
      .dout   (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle: drive at negedge, sample _rd before the edge, advance
   // the reference model, sample outputs 1ns after the edge, return at negedge.
   task automatic cycle(input logic rd_v);
      logic [7:0] head;
      logic       do_pop;
      rd       = rd_v;
      up_empty = !(up_avail && up_q.size() != 0);
      up_dout  = (up_q.size() != 0) ? up_q[0] : 8'h00;
      #1;
      obs_up_rd = up_rd;
      exp_up_rd = rst && !up_empty && (m_q.size() != 2);
      do_pop    = rd_v && rst && (m_q.size() != 0);
      head      = up_dout;
      @(posedge clk);
      #1;
      last_pop = do_pop;
      if (do_pop) exp_dout = m_q.pop_front();
      if (obs_up_rd && up_q.size() != 0) void'(up_q.pop_front());
      if (exp_up_rd) m_q.push_back(head);
      @(negedge clk);
   endtask

   task automatic test_reset();
      up_q.delete();
      m_q.delete();
      up_q.push_back(8'h5A);
      up_avail = 1'b1;
      rd       = 1'b0;
      up_empty = 1'b0;
      up_dout  = 8'h5A;
      rst      = 1'b1;
      #3;
      rst = 1'b0;
      #1;
      total_cnt++;
      if (up_rd !== 1'b0) $display("[TB] FAIL reset_rd: got %b expected 0", up_rd);
      else pass_cnt++;
      total_cnt++;
      if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", empty);
      else pass_cnt++;
      total_cnt++;
      if (dout !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected 00", dout);
      else pass_cnt++;
      exp_dout = 8'h00;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_word();
      cycle(1'b0);
      total_cnt++;
      if (obs_up_rd !== 1'b1) $display("[TB] FAIL single_push_rd: got %b expected 1", obs_up_rd);
      else pass_cnt++;
      total_cnt++;
      if (empty !== 1'b0) $display("[TB] FAIL single_not_empty: got %b expected 0", empty);
      else pass_cnt++;
      total_cnt++;
      if (dout !== 8'h00) $display("[TB] FAIL single_dout_before: got %h expected 00", dout);
      else pass_cnt++;
      cycle(1'b1);
      total_cnt++;
      if (dout !== 8'h5A) $display("[TB] FAIL single_dout: got %h expected 5a", dout);
      else pass_cnt++;
      total_cnt++;
      if (empty !== 1'b1) $display("[TB] FAIL single_empty_after: got %b expected 1", empty);
      else pass_cnt++;
      cycle(1'b0);
      total_cnt++;
      if (dout !== 8'h5A) $display("[TB] FAIL single_dout_hold: got %h expected 5a", dout);
      else pass_cnt++;
   endtask

   task automatic test_streaming();
      logic [7:0] sw [8];
      logic [7:0] want;
      sw = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};
      for (int i = 0; i < 8; i++) up_q.push_back(sw[i]);
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b1);
         want = (k < 2) ? 8'h5A : sw[(k - 2 > 7) ? 7 : k - 2];
         total_cnt++;
         if (dout !== want) $display("[TB] FAIL stream_dout[%0d]: got %h expected %h", k, dout, want);
         else pass_cnt++;
         total_cnt++;
         if (empty !== (k >= 9)) $display("[TB] FAIL stream_empty[%0d]: got %b expected %b", k, empty, k >= 9);
         else pass_cnt++;
         total_cnt++;
         if (obs_up_rd !== (k <= 8)) $display("[TB] FAIL stream_up_rd[%0d]: got %b expected %b", k, obs_up_rd, k <= 8);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] want_d [5];
      logic       want_e [5];
      want_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      want_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      up_q.push_back(8'h11);
      up_q.push_back(8'h22);
      up_q.push_back(8'h33);
      up_q.push_back(8'h44);
      for (int k = 1; k <= 4; k++) begin
         cycle(1'b0);
         total_cnt++;
         if (obs_up_rd !== (k <= 2)) $display("[TB] FAIL bp_up_rd[%0d]: got %b expected %b", k, obs_up_rd, k <= 2);
         else pass_cnt++;
         total_cnt++;
         if (dout !== 8'h7A) $display("[TB] FAIL bp_dout_hold[%0d]: got %h expected 7a", k, dout);
         else pass_cnt++;
      end
      total_cnt++;
      if (up_q.size() != 2) $display("[TB] FAIL bp_push_count: got %0d left upstream expected 2", up_q.size());
      else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1);
         total_cnt++;
         if (dout !== want_d[k]) $display("[TB] FAIL bp_dout[%0d]: got %h expected %h", k, dout, want_d[k]);
         else pass_cnt++;
         total_cnt++;
         if (empty !== want_e[k]) $display("[TB] FAIL bp_empty[%0d]: got %b expected %b", k, empty, want_e[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_underflow();
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1);
         total_cnt++;
         if (dout !== 8'h44) $display("[TB] FAIL uf_dout[%0d]: got %h expected 44", k, dout);
         else pass_cnt++;
         total_cnt++;
         if (empty !== 1'b1) $display("[TB] FAIL uf_empty[%0d]: got %b expected 1", k, empty);
         else pass_cnt++;
      end
      up_q.push_back(8'h9C);
      cycle(1'b1);
      total_cnt++;
      if (dout !== 8'h44 || empty !== 1'b0)
         $display("[TB] FAIL uf_fill: got dout=%h empty=%b expected dout=44 empty=0", dout, empty);
      else pass_cnt++;
      cycle(1'b1);
      total_cnt++;
      if (dout !== 8'h9C || empty !== 1'b1)
         $display("[TB] FAIL uf_first_word: got dout=%h empty=%b expected dout=9c empty=1", dout, empty);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int  delivered = 0;
      int  cycles    = 0;
      int  fails     = 0;
      bit  did_reset = 0;
      while (delivered < 1000 && cycles < 20000) begin
         while (up_q.size() < 3) up_q.push_back(8'($urandom_range(0, 255)));
         up_avail = 1'($urandom_range(0, 1));
         cycle(1'($urandom_range(0, 1)));
         cycles++;
         if (last_pop) delivered++;
         total_cnt++;
         if (obs_up_rd !== exp_up_rd || dout !== exp_dout || empty !== (m_q.size() == 0)) begin
            fails++;
            if (fails <= 20)
               $display("[TB] FAIL rand[%0d]: got rd=%b dout=%h empty=%b expected rd=%b dout=%h empty=%b",
                        cycles, obs_up_rd, dout, empty, exp_up_rd, exp_dout, m_q.size() == 0);
         end else pass_cnt++;
         if (delivered >= 500 && !did_reset && m_q.size() != 0) begin
            did_reset = 1;
            rst = 1'b0;
            #1;
            total_cnt++;
            if (dout !== 8'h00 || empty !== 1'b1 || up_rd !== 1'b0)
               $display("[TB] FAIL rand_reset: got dout=%h empty=%b rd=%b expected dout=00 empty=1 rd=0",
                        dout, empty, up_rd);
            else pass_cnt++;
            m_q.delete();
            exp_dout = 8'h00;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
         end
      end
      total_cnt++;
      if (delivered < 1000) $display("[TB] FAIL rand_budget: got %0d words expected 1000", delivered);
      else pass_cnt++;
      total_cnt++;
      if (!did_reset) $display("[TB] FAIL rand_reset_taken: got 0 expected 1");
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_streaming();
      test_backpressure();
      test_underflow();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
